nn_feature_loader: RTL

- Upstream stage of neural_network: converts a serial stream of 16-bit feature words into the 22 parallel inputs in0..in21.
- Collects one frame of N_FEAT words into a fill buffer, then transfers it into an output register that drives the network inputs and stays stable until acknowledged.
- Words of the next frame can be loaded while the current frame is presented, so the network always sees a complete, glitch-free input set.

---
 rtl/nn_feature_loader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/nn_feature_loader.sv
// Feature loader: packs a serial stream of DW-bit feature words into one
// N_FEAT-word frame and presents it on a held, acknowledged output register.
// The next frame fills in the background while the current one is presented.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_valid/s_ready     stream handshake (s_ready is combinational)
//   s_data, s_last      stream word and end-of-frame marker
//   feat_flat           presented frame, word k at [k*DW +: DW]
//   feat_valid          feat_flat holds a complete frame
//   feat_ack            consumer has used the presented frame
//   frame_err           one-cycle pulse on a framing error
//   frame_count         frames transferred to the output register (wraps)
module nn_feature_loader #(
    parameter int unsigned N_FEAT = 22,
    parameter int unsigned DW     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DW-1:0]        s_data,
    input  logic                 s_last,
    output logic [N_FEAT*DW-1:0] feat_flat,
    output logic                 feat_valid,
    input  logic                 feat_ack,
    output logic                 frame_err,
    output logic [15:0]          frame_count
);

    localparam int unsigned IDX_W  = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int unsigned FLAT_W = N_FEAT * DW;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_FEAT - 1);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        DROP = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_n;
    logic [FLAT_W-1:0]  fill;
    logic               accept;
    logic               store;
    logic               xfer;
    logic               err_n;

    assign s_ready = !rst && ((state == FILL) || (state == DROP));
    assign accept  = s_valid && s_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_n;
        end
    end

    // Next state, word store strobe, transfer strobe and error detection
    always_comb begin
        state_n = state;
        idx_n   = idx;
        store   = 1'b0;
        xfer    = 1'b0;
        err_n   = 1'b0;
        case (state)
            FILL: begin
                if (accept) begin
                    if (idx == IDX_LAST) begin
                        idx_n = '0;
                        if (s_last) begin
                            store   = 1'b1;
                            state_n = FULL;
                        end else begin
                            // Missing last: swallow the rest of this frame
                            err_n   = 1'b1;
                            state_n = DROP;
                        end
                    end else if (s_last) begin
                        // Early last: partial frame discarded, restart at word 0
                        err_n = 1'b1;
                        idx_n = '0;
                    end else begin
                        store = 1'b1;
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            DROP: begin
                if (accept && s_last) begin
                    state_n = FILL;
                end
            end
            FULL: begin
                // Transfer when the output register is free or being released now
                if (!feat_valid || feat_ack) begin
                    xfer    = 1'b1;
                    state_n = FILL;
                end
            end
            default: begin
                state_n = FILL;
            end
        endcase
    end

    // Fill buffer; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (store) begin
            fill[idx*DW +: DW] <= s_data;
        end
    end

    // Index, output register, error pulse and frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            feat_flat   <= '0;
            feat_valid  <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= '0;
        end else begin
            idx       <= idx_n;
            frame_err <= err_n;
            if (xfer) begin
                feat_flat   <= fill;
                feat_valid  <= 1'b1;
                frame_count <= frame_count + 16'd1;
            end else if (feat_ack) begin
                feat_valid <= 1'b0;
            end
        end
    end

endmodule
